// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Round-robin arbiter that shares NR_PORTS writeback/bypass ports between
// NR_REQ functional-unit result producers. Each cycle, the arbiter scans the
// requesters starting at the round-robin pointer. It grants up to NR_PORTS of
// them, and the j-th grant in scan order lands on port j. Granted payloads
// appear on registered port outputs one cycle later. A squash suppresses all
// grants, empties the ports on the next edge and clears the wait counters.
// A saturating wait counter per requester drives a registered starvation flag.
//
// Parameters
//   NR_REQ       number of result producers
//   NR_PORTS     number of writeback ports (1 <= NR_PORTS <= NR_REQ)
//   DATA_W       pc / result width (XLEN)
//   ID_W         instruction id width
//   STARVE_LIMIT wait-cycle threshold for starve_o
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   req_valid_i      per-requester result valid
//   req_ready_o      per-requester grant (combinational, gated by squash)
//   req_id_i/pc_i/data_i   per-requester payload
//   port_valid_o     per-port valid (registered)
//   port_id_o/pc_o/data_o  per-port payload (registered)
//   port_src_o       index of the requester that fed each port (registered)
//   squash_valid_i   pipeline squash
//   starve_o         per-requester starvation flag (registered)
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int NR_REQ       = 4,
    parameter int NR_PORTS     = 2,
    parameter int DATA_W       = 32,
    parameter int ID_W         = 8,
    parameter int STARVE_LIMIT = 8,
    localparam int SRC_W       = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NR_REQ-1:0]   req_valid_i,
    output logic [NR_REQ-1:0]   req_ready_o,
    input  logic [ID_W-1:0]     req_id_i   [NR_REQ],
    input  logic [DATA_W-1:0]   req_pc_i   [NR_REQ],
    input  logic [DATA_W-1:0]   req_data_i [NR_REQ],
    output logic [NR_PORTS-1:0] port_valid_o,
    output logic [ID_W-1:0]     port_id_o   [NR_PORTS],
    output logic [DATA_W-1:0]   port_pc_o   [NR_PORTS],
    output logic [DATA_W-1:0]   port_data_o [NR_PORTS],
    output logic [SRC_W-1:0]    port_src_o  [NR_PORTS],
    input  logic                squash_valid_i,
    output logic [NR_REQ-1:0]   starve_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    // Round-robin state and scan results
    logic [SRC_W-1:0]    rr_ptr_r;
    logic [SRC_W-1:0]    rr_ptr_nxt_s;
    logic [NR_REQ-1:0]   grant_s;
    logic [SRC_W-1:0]    last_s;
    logic [SRC_W-1:0]    sel_s [NR_PORTS];
    logic [NR_PORTS-1:0] use_s;
    logic                xfer_any_s;
    int                  scan_idx_s;
    int                  n_grant_s;

    // Port output registers
    logic [NR_PORTS-1:0] port_valid_r;
    logic [ID_W-1:0]     port_id_r   [NR_PORTS];
    logic [DATA_W-1:0]   port_pc_r   [NR_PORTS];
    logic [DATA_W-1:0]   port_data_r [NR_PORTS];
    logic [SRC_W-1:0]    port_src_r  [NR_PORTS];

    // Starvation tracking
    logic [CNT_W-1:0]    wait_cnt_r   [NR_REQ];
    logic [CNT_W-1:0]    wait_cnt_nxt_s [NR_REQ];
    logic [NR_REQ-1:0]   starve_r;
    logic [NR_REQ-1:0]   starve_nxt_s;

    // Rotating scan from rr_ptr: the first NR_PORTS valid requesters fill ports 0.. in order
    always_comb begin
        grant_s    = '0;
        use_s      = '0;
        last_s     = rr_ptr_r;
        n_grant_s  = 0;
        scan_idx_s = 0;
        for (int k = 0; k < NR_PORTS; k++) begin
            sel_s[k] = '0;
        end
        for (int j = 0; j < NR_REQ; j++) begin
            scan_idx_s = ((int'(rr_ptr_r) + j) >= NR_REQ) ? (int'(rr_ptr_r) + j - NR_REQ)
                                                          : (int'(rr_ptr_r) + j);
            if (req_valid_i[SRC_W'(scan_idx_s)] && (n_grant_s < NR_PORTS)) begin
                grant_s[SRC_W'(scan_idx_s)] = 1'b1;
                // constant-index fan-out keeps the port select free of runtime array indexing
                for (int k = 0; k < NR_PORTS; k++) begin
                    if (k == n_grant_s) begin
                        sel_s[k] = SRC_W'(scan_idx_s);
                        use_s[k] = 1'b1;
                    end else begin
                        sel_s[k] = sel_s[k];
                    end
                end
                last_s    = SRC_W'(scan_idx_s);
                n_grant_s = n_grant_s + 1;
            end else begin
                n_grant_s = n_grant_s;
            end
        end
    end

    // Handshake and pointer advance: squash blocks every grant and freezes the pointer
    always_comb begin
        req_ready_o  = grant_s & {NR_REQ{~squash_valid_i}};
        xfer_any_s   = (|grant_s) & ~squash_valid_i;
        rr_ptr_nxt_s = rr_ptr_r;
        if (xfer_any_s) begin
            if (last_s == SRC_W'(NR_REQ - 1)) begin
                rr_ptr_nxt_s = '0;
            end else begin
                rr_ptr_nxt_s = last_s + {{(SRC_W-1){1'b0}}, 1'b1};
            end
        end else begin
            rr_ptr_nxt_s = rr_ptr_r;
        end
    end

    // Wait counters: clear on squash, idle or transfer; otherwise saturate at the limit
    always_comb begin
        starve_nxt_s = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            wait_cnt_nxt_s[i] = wait_cnt_r[i];
            if (squash_valid_i || !req_valid_i[i] || req_ready_o[i]) begin
                wait_cnt_nxt_s[i] = '0;
            end else if (wait_cnt_r[i] >= CNT_W'(STARVE_LIMIT)) begin
                wait_cnt_nxt_s[i] = CNT_W'(STARVE_LIMIT);
            end else begin
                wait_cnt_nxt_s[i] = wait_cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            starve_nxt_s[i] = (wait_cnt_nxt_s[i] >= CNT_W'(STARVE_LIMIT));
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_r <= '0;
        end else begin
            rr_ptr_r <= rr_ptr_nxt_s;
        end
    end

    // Port registers: load granted payloads, drop valid on unused ports, hold stale payload
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            port_valid_r <= '0;
            for (int k = 0; k < NR_PORTS; k++) begin
                port_id_r[k]   <= '0;
                port_pc_r[k]   <= '0;
                port_data_r[k] <= '0;
                port_src_r[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NR_PORTS; k++) begin
                if (squash_valid_i) begin
                    port_valid_r[k] <= 1'b0;
                end else if (use_s[k]) begin
                    port_valid_r[k] <= 1'b1;
                    port_id_r[k]    <= req_id_i[sel_s[k]];
                    port_pc_r[k]    <= req_pc_i[sel_s[k]];
                    port_data_r[k]  <= req_data_i[sel_s[k]];
                    port_src_r[k]   <= sel_s[k];
                end else begin
                    port_valid_r[k] <= 1'b0;
                end
            end
        end
    end

    // Wait counters and registered starvation flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_r <= '0;
            for (int i = 0; i < NR_REQ; i++) begin
                wait_cnt_r[i] <= '0;
            end
        end else begin
            starve_r <= starve_nxt_s;
            for (int i = 0; i < NR_REQ; i++) begin
                wait_cnt_r[i] <= wait_cnt_nxt_s[i];
            end
        end
    end

    assign port_valid_o = port_valid_r;
    assign port_id_o    = port_id_r;
    assign port_pc_o    = port_pc_r;
    assign port_data_o  = port_data_r;
    assign port_src_o   = port_src_r;
    assign starve_o     = starve_r;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// Scoreboard bench for wb_port_arbiter. The stimulus pushes the expected port
// contents for every grant it issues. A monitor on the falling edge pops the
// queue and compares whenever a port shows valid. A second instance with one
// port and STARVE_LIMIT=2 lets a requester wait long enough to raise its flag.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;

    typedef struct {
        int          port;
        logic [1:0]  src;
        logic [7:0]  id;
        logic [31:0] pc;
        logic [31:0] data;
    } item_t;

    logic        clk;
    logic        rstn;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  req_id   [4];
    logic [31:0] req_pc   [4];
    logic [31:0] req_data [4];
    logic [1:0]  port_valid;
    logic [7:0]  port_id   [2];
    logic [31:0] port_pc   [2];
    logic [31:0] port_data [2];
    logic [1:0]  port_src  [2];
    logic        squash;
    logic [3:0]  starve;

    logic [3:0]  v2;
    logic [3:0]  rdy2;
    logic        sq2;
    logic [3:0]  starve2;
    logic [7:0]  id2   [4];
    logic [31:0] pc2   [4];
    logic [31:0] data2 [4];
    logic [0:0]  pv2;
    logic [7:0]  pid2   [1];
    logic [31:0] ppc2   [1];
    logic [31:0] pdata2 [1];
    logic [1:0]  psrc2  [1];

    int    tests;
    int    fails;
    int    stp;
    logic  special;
    item_t sb [$];
    item_t mon_it;
    item_t push_it;

    wb_port_arbiter dut (
        .clk(clk), .rstn(rstn),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_id_i(req_id), .req_pc_i(req_pc), .req_data_i(req_data),
        .port_valid_o(port_valid), .port_id_o(port_id), .port_pc_o(port_pc),
        .port_data_o(port_data), .port_src_o(port_src),
        .squash_valid_i(squash), .starve_o(starve)
    );

    wb_port_arbiter #(.NR_PORTS(1), .STARVE_LIMIT(2)) dut2 (
        .clk(clk), .rstn(rstn),
        .req_valid_i(v2), .req_ready_o(rdy2),
        .req_id_i(id2), .req_pc_i(pc2), .req_data_i(data2),
        .port_valid_o(pv2), .port_id_o(pid2), .port_pc_o(ppc2),
        .port_data_o(pdata2), .port_src_o(psrc2),
        .squash_valid_i(sq2), .starve_o(starve2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Payload model: each step gives requester i a distinct, step-dependent payload
    function automatic logic [7:0] f_id(input int i);
        return (special && i == 2) ? 8'h05 : 8'(stp * 4 + i);
    endfunction
    function automatic logic [31:0] f_pc(input int i);
        return 32'h0000_1000 + 32'(stp * 16 + i * 4);
    endfunction
    function automatic logic [31:0] f_data(input int i);
        return (special && i == 2) ? 32'h0000_00AB : 32'hC0DE_0000 + 32'(stp * 256 + i);
    endfunction

    task automatic push_exp(input int port, input int src);
        push_it.port = port;
        push_it.src  = 2'(src);
        push_it.id   = f_id(src);
        push_it.pc   = f_pc(src);
        push_it.data = f_data(src);
        sb.push_back(push_it);
    endtask

    // One arbitration cycle on the main instance: drive, check ready, queue expected ports
    task automatic step(input logic [3:0] v, input logic sq, input logic [3:0] exp_rdy,
                        input int n, input int s0, input int s1);
        for (int i = 0; i < 4; i++) begin
            req_id[i]   = f_id(i);
            req_pc[i]   = f_pc(i);
            req_data[i] = f_data(i);
        end
        req_valid = v;
        squash    = sq;
        #1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (n > 0) push_exp(0, s0);
        if (n > 1) push_exp(1, s1);
        @(posedge clk);
        #2;
        chk("port_valid", 32'(port_valid), (n == 2) ? 32'd3 : ((n == 1) ? 32'd1 : 32'd0));
        chk("starve", 32'(starve), 32'd0);
        stp++;
    endtask

    // One cycle on the single-port instance, checking grant and starvation flags
    task automatic step2(input logic [3:0] v, input logic sq, input logic [3:0] exp_rdy,
                         input logic [3:0] exp_starve);
        v2  = v;
        sq2 = sq;
        #1;
        chk("dut2_ready", 32'(rdy2), 32'(exp_rdy));
        @(posedge clk);
        #2;
        chk("dut2_starve", 32'(starve2), 32'(exp_starve));
    endtask

    // Monitor: every valid port must match the next queued expectation
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (port_valid[k]) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL port%0d_unexpected: got src %0d expected no output", k, port_src[k]);
                end else begin
                    mon_it = sb.pop_front();
                    chk("port_index", 32'(k), 32'(mon_it.port));
                    chk("port_src", 32'(port_src[k]), 32'(mon_it.src));
                    chk("port_id", 32'(port_id[k]), 32'(mon_it.id));
                    chk("port_pc", port_pc[k], mon_it.pc);
                    chk("port_data", port_data[k], mon_it.data);
                end
            end
        end
    end

    initial begin
        tests     = 0;
        fails     = 0;
        stp       = 0;
        special   = 1'b0;
        rstn      = 1'b0;
        req_valid = 4'b0000;
        squash    = 1'b0;
        v2        = 4'b0000;
        sq2       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_id[i] = 8'h00; req_pc[i] = 32'h0; req_data[i] = 32'h0;
            id2[i]    = 8'h00; pc2[i]    = 32'h0; data2[i]    = 32'h0;
        end
        #1;
        chk("reset_port_valid", 32'(port_valid), 32'd0);
        chk("reset_port_id0", 32'(port_id[0]), 32'd0);
        chk("reset_port_src1", 32'(port_src[1]), 32'd0);
        chk("reset_starve", 32'(starve), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rstn = 1'b1;

        // Idle after reset
        step(4'b0000, 1'b0, 4'b0000, 0, 0, 0);
        // Full load fairness from pointer 0
        step(4'b1111, 1'b0, 4'b0011, 2, 0, 1);
        step(4'b1111, 1'b0, 4'b1100, 2, 2, 3);
        step(4'b1111, 1'b0, 4'b0011, 2, 0, 1);
        step(4'b1111, 1'b0, 4'b1100, 2, 2, 3);
        // Single request: req 2, id 5, data 0xAB; pointer moves to 3
        special = 1'b1;
        step(4'b0100, 1'b0, 4'b0100, 1, 2, 0);
        special = 1'b0;
        // Wrap: scan 3 then 0; pointer becomes 1
        step(4'b1001, 1'b0, 4'b1001, 2, 3, 0);
        // Squash against three valid requests: no grant, ports empty, pointer kept at 1
        step(4'b1110, 1'b1, 4'b0000, 0, 0, 0);
        step(4'b1110, 1'b0, 4'b0110, 2, 1, 2);
        // req 3 still waiting, req 0 joins: wrap again, pointer becomes 1
        step(4'b1001, 1'b0, 4'b1001, 2, 3, 0);
        // No requests: ports empty, pointer held at 1
        step(4'b0000, 1'b0, 4'b0000, 0, 0, 0);
        step(4'b1111, 1'b0, 4'b0110, 2, 1, 2);

        // Reset mid-cycle with both ports holding results; that cycle's grant is lost
        req_valid = 4'b1111;
        #1;
        chk("pre_reset_ready", 32'(req_ready), 32'b1001);
        #3;
        req_valid = 4'b0000;
        rstn      = 1'b0;
        #1;
        chk("midreset_port_valid", 32'(port_valid), 32'd0);
        chk("midreset_port_data0", port_data[0], 32'd0);
        chk("midreset_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        step(4'b0000, 1'b0, 4'b0000, 0, 0, 0);
        // Pointer restarted at 0
        step(4'b1111, 1'b0, 4'b0011, 2, 0, 1);
        step(4'b0000, 1'b0, 4'b0000, 0, 0, 0);

        // Starvation on the single-port instance (limit 2)
        step2(4'b0010, 1'b1, 4'b0000, 4'b0000);
        step2(4'b0010, 1'b1, 4'b0000, 4'b0000);
        step2(4'b0010, 1'b1, 4'b0000, 4'b0000);
        step2(4'b0010, 1'b0, 4'b0010, 4'b0000);
        step2(4'b1110, 1'b0, 4'b0100, 4'b0000);
        step2(4'b1110, 1'b0, 4'b1000, 4'b0010);
        step2(4'b1110, 1'b0, 4'b0010, 4'b0100);
        step2(4'b0000, 1'b0, 4'b0000, 4'b0000);

        @(posedge clk);
        #2;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
